// File: rtl/eth_frame_rx.sv
`timescale 1ns/1ps
// eth_frame_rx: RMII frame receiver: preamble/SFD, destination filter, source/length capture, payload repack, FCS strip, verdict.
// Latency: a full word appears one cycle after the byte that pushes it out of the holdback; the last word, done and good one cycle after carrier drop.
// Backpressure: none. The RMII line cannot be stalled, so the output stream must be accepted every cycle it is valid.
//
// Ports:
//   clk_in, rst_in        50 MHz RMII reference clock, synchronous active-high reset
//   crsdv_in, rxd_in      PHY carrier-sense/data-valid and receive dibit (bits [1:0] of a byte arrive first)
//   axiov/axiod/axiok/axiol  payload word stream (first byte in MS byte, MSB-aligned keep, last flag)
//   done_out, good_out    end-of-frame pulse and verdict
//   src_mac_out, len_out  captured source address and length/type field
//   drop_count_out        saturating count of frames dropped in preamble or by the address filter
// Build option: define ETH_FRAME_RX_CRC_EN to build the CRC-32 residue check into the verdict.

module eth_frame_rx #(
    parameter int          OUT_W        = 32,
    parameter logic [47:0] MAC_ADDR     = 48'h0000_0000_0000,
    parameter int          MIN_PREAMBLE = 16,
    parameter int          CNT_W        = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               crsdv_in,
    input  logic [1:0]         rxd_in,
    output logic               axiov,
    output logic [OUT_W-1:0]   axiod,
    output logic [OUT_W/8-1:0] axiok,
    output logic               axiol,
    output logic               done_out,
    output logic               good_out,
    output logic [47:0]        src_mac_out,
    output logic [15:0]        len_out,
    output logic [CNT_W-1:0]   drop_count_out
);

    localparam int NB  = OUT_W / 8;
    localparam int WCW = $clog2(NB + 1);
    localparam int PW  = $clog2(MIN_PREAMBLE + 2);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_PRE,
        S_DEST,
        S_SRC,
        S_LEN,
        S_PAY,
        S_DROP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_phase;    // dibit position within the current byte
    logic [5:0]       r_sh;       // first three dibits of the byte being assembled
    logic [2:0]       r_bcnt;     // byte index within the current header field
    logic [PW-1:0]    r_pre_cnt;  // consecutive 01 dibits, saturating at MIN_PREAMBLE
    logic [39:0]      r_addr;     // header bytes seen so far in the current field
    logic [31:0]      r_hold;     // 4-byte holdback; the oldest byte sits in [31:24] when full
    logic [2:0]       r_hcnt;     // bytes currently held back (0..4)
    logic [OUT_W-1:0] r_word;     // payload word under construction
    logic [WCW-1:0]   r_wcnt;     // bytes already placed in r_word

    logic [7:0]       w_byte;
    logic             w_byte_done;
    logic [7:0]       w_pop;
    logic             w_crc_ok;

    // The dibit on the wire this cycle is the top two bits of the byte.
    assign w_byte      = {rxd_in, r_sh};
    assign w_byte_done = crsdv_in && (r_phase == 2'd3);
    assign w_pop       = r_hold[31:24];

    function automatic logic [NB-1:0] keep_of(input logic [WCW-1:0] n);
        logic [NB-1:0] k;
        k = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(n)) k[NB-1-i] = 1'b1;
        end
        return k;
    endfunction

`ifdef ETH_FRAME_RX_CRC_EN
    logic [31:0] r_crc;

    // Reflected CRC-32, two bits per clock, bit 0 of the dibit first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_crc <= '1;
        end else if (r_state == S_IDLE || r_state == S_PRE) begin
            r_crc <= '1;
        end else if (crsdv_in && (r_state == S_DEST || r_state == S_SRC ||
                                  r_state == S_LEN  || r_state == S_PAY)) begin
            r_crc <= crc_dibit(r_crc, rxd_in);
        end
    end

    // Running the register over data plus the appended FCS leaves a fixed residue.
    assign w_crc_ok = (r_crc == 32'hDEBB_20E3);
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_ARM;
            r_phase        <= '0;
            r_sh           <= '0;
            r_bcnt         <= '0;
            r_pre_cnt      <= '0;
            r_addr         <= '0;
            r_hold         <= '0;
            r_hcnt         <= '0;
            r_word         <= '0;
            r_wcnt         <= '0;
            axiov          <= 1'b0;
            axiod          <= '0;
            axiok          <= '0;
            axiol          <= 1'b0;
            done_out       <= 1'b0;
            good_out       <= 1'b0;
            src_mac_out    <= '0;
            len_out        <= '0;
            drop_count_out <= '0;
        end else begin
            axiov    <= 1'b0;
            axiol    <= 1'b0;
            done_out <= 1'b0;
            good_out <= 1'b0;

            if (crsdv_in) begin
                r_sh    <= {rxd_in, r_sh[5:2]};
                r_phase <= r_phase + 2'd1;
            end

            case (r_state)
                // Ignore whatever frame is on the line when reset releases.
                S_ARM: begin
                    if (!crsdv_in) r_state <= S_IDLE;
                end

                S_IDLE: begin
                    r_phase   <= '0;
                    r_pre_cnt <= PW'(1);
                    r_hcnt    <= '0;
                    r_wcnt    <= '0;
                    if (crsdv_in && rxd_in == 2'b01) r_state <= S_PRE;
                end

                S_PRE: begin
                    r_phase <= '0;
                    r_bcnt  <= '0;
                    if (!crsdv_in) begin
                        // Carrier vanished before any SFD: line noise, not a frame.
                        r_state <= S_IDLE;
                    end else if (rxd_in == 2'b01) begin
                        if (r_pre_cnt < PW'(MIN_PREAMBLE)) r_pre_cnt <= r_pre_cnt + 1'b1;
                    end else if (rxd_in == 2'b11 && r_pre_cnt >= PW'(MIN_PREAMBLE)) begin
                        r_state <= S_DEST;
                    end else begin
                        r_state <= S_DROP;
                        if (drop_count_out != {CNT_W{1'b1}}) drop_count_out <= drop_count_out + 1'b1;
                    end
                end

                S_DEST, S_SRC, S_LEN: begin
                    if (!crsdv_in) begin
                        // Runt frame: report it as bad, but it is not a filter drop.
                        done_out <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_byte_done) begin
                        r_addr <= {r_addr[31:0], w_byte};
                        r_bcnt <= r_bcnt + 3'd1;
                        if (r_state == S_DEST && r_bcnt == 3'd5) begin
                            r_bcnt <= '0;
                            if ({r_addr, w_byte} == MAC_ADDR || {r_addr, w_byte} == 48'hFFFF_FFFF_FFFF) begin
                                r_state <= S_SRC;
                            end else begin
                                r_state <= S_DROP;
                                if (drop_count_out != {CNT_W{1'b1}}) drop_count_out <= drop_count_out + 1'b1;
                            end
                        end else if (r_state == S_SRC && r_bcnt == 3'd5) begin
                            r_bcnt      <= '0;
                            src_mac_out <= {r_addr, w_byte};
                            r_state     <= S_LEN;
                        end else if (r_state == S_LEN && r_bcnt == 3'd1) begin
                            r_bcnt  <= '0;
                            len_out <= {r_addr[7:0], w_byte};
                            r_hcnt  <= '0;
                            r_wcnt  <= '0;
                            r_word  <= '0;
                            r_state <= S_PAY;
                        end
                    end
                end

                S_PAY: begin
                    if (!crsdv_in) begin
                        // The four held bytes are the FCS and are simply dropped.
                        // A non-empty word register implies at least 1 payload + 4 FCS bytes.
                        if (r_wcnt != '0) begin
                            axiov <= 1'b1;
                            axiol <= 1'b1;
                            axiod <= r_word;
                            axiok <= keep_of(r_wcnt);
                        end
                        done_out <= 1'b1;
                        good_out <= (r_wcnt != '0) && (r_phase == 2'd0) && w_crc_ok;
                        r_state  <= S_IDLE;
                    end else if (w_byte_done) begin
                        r_hold <= {r_hold[23:0], w_byte};
                        if (r_hcnt != 3'd4) begin
                            r_hcnt <= r_hcnt + 3'd1;
                        end else if (r_wcnt == WCW'(NB)) begin
                            // Emit only once more payload is known to exist, so the
                            // final word is never empty and always carries the last flag.
                            axiov  <= 1'b1;
                            axiod  <= r_word;
                            axiok  <= '1;
                            r_word <= '0;
                            r_word[OUT_W-1 -: 8] <= w_pop;
                            r_wcnt <= WCW'(1);
                        end else begin
                            for (int b = 0; b < NB; b++) begin
                                if (WCW'(b) == r_wcnt) r_word[OUT_W-8-8*b +: 8] <= w_pop;
                            end
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end

                S_DROP: begin
                    if (!crsdv_in) r_state <= S_IDLE;
                end

                default: r_state <= S_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_rx.sv
`timescale 1ns/1ps
// tb_eth_frame_rx: directed checks of the RMII frame receiver with a bench-built FCS.
// Latency: checks last word/done/good one cycle after carrier drop.
// Backpressure: none; the monitor records every valid word.

module tb_eth_frame_rx;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        crsdv_in;
    logic [1:0]  rxd_in;
    logic        axiov;
    logic [31:0] axiod;
    logic [3:0]  axiok;
    logic        axiol;
    logic        done_out;
    logic        good_out;
    logic [47:0] src_mac_out;
    logic [15:0] len_out;
    logic [15:0] drop_count_out;

    eth_frame_rx #(
        .OUT_W        (32),
        .MAC_ADDR     (48'h0000_0000_0000),
        .MIN_PREAMBLE (16),
        .CNT_W        (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .crsdv_in       (crsdv_in),
        .rxd_in         (rxd_in),
        .axiov          (axiov),
        .axiod          (axiod),
        .axiok          (axiok),
        .axiol          (axiol),
        .done_out       (done_out),
        .good_out       (good_out),
        .src_mac_out    (src_mac_out),
        .len_out        (len_out),
        .drop_count_out (drop_count_out)
    );

    always #10 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] SRC_MAC = 48'h96C2_0830_75FD;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic [7:0]  frame[$];
    logic [7:0]  pay[$];
    logic [31:0] mon_d[$];
    logic [3:0]  mon_k[$];
    logic        mon_l[$];
    logic        mon_g[$];

    always @(negedge clk_in) begin
        if (axiov === 1'b1) begin
            mon_d.push_back(axiod);
            mon_k.push_back(axiok);
            mon_l.push_back(axiol);
        end
        if (done_out === 1'b1) mon_g.push_back(good_out);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_d.delete();
        mon_k.delete();
        mon_l.delete();
        mon_g.delete();
    endtask

    task automatic drive(input logic c, input logic [1:0] d);
        @(negedge clk_in);
        crsdv_in = c;
        rxd_in   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2]);
    endtask

    task automatic send_preamble(input int bad_pos);
        for (int i = 0; i < 31; i++) drive(1'b1, (i == bad_pos) ? 2'b00 : 2'b01);
        drive(1'b1, 2'b11);
    endtask

    task automatic send_frame(input int bad_pos, input int extra);
        send_preamble(bad_pos);
        foreach (frame[k]) send_byte(frame[k]);
        for (int i = 0; i < extra; i++) drive(1'b1, 2'b10);
    endtask

    // Standard Ethernet FCS: reflected CRC-32, inverted, appended low byte first.
    task automatic build_frame(input logic [47:0] dst, input int npay);
        logic [31:0] c;
        logic        fb;
        frame.delete();
        pay.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(SRC_MAC[47-8*i -: 8]);
        frame.push_back(8'h00);
        frame.push_back(8'(npay));
        for (int i = 0; i < npay; i++) begin
            pay.push_back(8'(8'h10 + i));
            frame.push_back(8'(8'h10 + i));
        end
        c = 32'hFFFF_FFFF;
        foreach (frame[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ frame[k][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        for (int j = 0; j < 4; j++) frame.push_back(c[8*j +: 8]);
    endtask

    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (4*w + b < pay.size()) r[31-8*b -: 8] = pay[4*w + b];
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_keep(input int w);
        logic [3:0] k;
        k = '0;
        for (int b = 0; b < 4; b++) begin
            if (4*w + b < pay.size()) k[3-b] = 1'b1;
        end
        return k;
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (k[3-b]) m[31-8*b -: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic test_reset();
        rst_in   = 1'b1;
        crsdv_in = 1'b0;
        rxd_in   = 2'b00;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({axiov, axiol, done_out, good_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {axiov, axiol, done_out, good_out});
        end
        n_checks++;
        if (axiod !== 32'h0 || axiok !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0", axiod, axiok);
        end
        n_checks++;
        if (src_mac_out !== 48'h0 || len_out !== 16'h0 || drop_count_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h/%h/%0d want 0/0/0", src_mac_out, len_out, drop_count_out);
        end
        rst_in = 1'b0;
        idle(3);
    endtask

    task automatic test_broadcast();
        clear_mon();
        build_frame(BCAST, 21);
        send_frame(-1, 0);
        drive(1'b0, 2'b00);
        @(negedge clk_in);
        n_checks++;
        if ({done_out, good_out, axiov, axiol} !== 4'b1111) begin
            n_fail++;
            $display("FAIL bc_end_timing: got done/good/v/l=%b want 1111", {done_out, good_out, axiov, axiol});
        end
        idle(3);
        n_checks++;
        if (mon_d.size() != 6) begin
            n_fail++;
            $display("FAIL bc_word_count: got %0d want 6", mon_d.size());
        end
        for (int w = 0; w < 6; w++) begin
            if (w < mon_d.size()) begin
                n_checks++;
                if ((mon_d[w] & keep_mask(exp_keep(w))) !== exp_word(w) || mon_k[w] !== exp_keep(w) ||
                    mon_l[w] !== (w == 5)) begin
                    n_fail++;
                    $display("FAIL bc_word%0d: got %h/%b/%b want %h/%b/%b", w, mon_d[w], mon_k[w], mon_l[w],
                             exp_word(w), exp_keep(w), (w == 5));
                end
            end
        end
        n_checks++;
        if (src_mac_out !== SRC_MAC || len_out !== 16'h0015) begin
            n_fail++;
            $display("FAIL bc_hdr: got %h/%h want %h/0015", src_mac_out, len_out, SRC_MAC);
        end
        n_checks++;
        if (mon_g.size() != 1 || drop_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL bc_done_count: got %0d dones drop %0d want 1 dones drop 0", mon_g.size(), drop_count_out);
        end
    endtask

    task automatic test_fcs_flip();
        logic exp_g;
`ifdef ETH_FRAME_RX_CRC_EN
        exp_g = 1'b0;
`else
        exp_g = 1'b1;
`endif
        clear_mon();
        build_frame(BCAST, 21);
        frame[frame.size()-2] = frame[frame.size()-2] ^ 8'h10;
        send_frame(-1, 0);
        idle(4);
        n_checks++;
        if (mon_d.size() != 6) begin
            n_fail++;
            $display("FAIL fcs_word_count: got %0d want 6", mon_d.size());
        end
        for (int w = 0; w < 6; w++) begin
            if (w < mon_d.size()) begin
                n_checks++;
                if ((mon_d[w] & keep_mask(exp_keep(w))) !== exp_word(w) || mon_k[w] !== exp_keep(w)) begin
                    n_fail++;
                    $display("FAIL fcs_word%0d: got %h/%b want %h/%b", w, mon_d[w], mon_k[w], exp_word(w), exp_keep(w));
                end
            end
        end
        n_checks++;
        if (mon_g.size() != 1 || (mon_g.size() == 1 && mon_g[0] !== exp_g)) begin
            n_fail++;
            $display("FAIL fcs_verdict: got %0d dones want 1 with good=%b", mon_g.size(), exp_g);
        end
    endtask

    task automatic test_dest_filter();
        clear_mon();
        build_frame(48'h0200_0000_0001, 21);
        send_frame(-1, 0);
        idle(4);
        n_checks++;
        if (mon_d.size() != 0 || mon_g.size() != 0) begin
            n_fail++;
            $display("FAIL filt_outputs: got %0d words %0d dones want 0 0", mon_d.size(), mon_g.size());
        end
        n_checks++;
        if (drop_count_out !== 16'd1) begin
            n_fail++;
            $display("FAIL filt_drop: got %0d want 1", drop_count_out);
        end
    endtask

    task automatic test_preamble_err();
        clear_mon();
        build_frame(BCAST, 21);
        send_frame(10, 0);
        idle(4);
        n_checks++;
        if (drop_count_out !== 16'd2 || mon_g.size() != 0 || mon_d.size() != 0) begin
            n_fail++;
            $display("FAIL pre_drop: got drop %0d dones %0d words %0d want 2 0 0", drop_count_out, mon_g.size(), mon_d.size());
        end
        send_frame(-1, 0);
        idle(4);
        n_checks++;
        if (mon_g.size() != 1 || (mon_g.size() == 1 && mon_g[0] !== 1'b1) || mon_d.size() != 6) begin
            n_fail++;
            $display("FAIL pre_recover: got %0d dones %0d words want 1 good and 6 words", mon_g.size(), mon_d.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build_frame(BCAST, 21);
        send_preamble(-1);
        for (int k = 0; k < 24; k++) send_byte(frame[k]);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'b01);
            rst_in = (i == 0);
            if (i == 3) clear_mon();
        end
        idle(4);
        n_checks++;
        if (mon_d.size() != 0 || mon_g.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %0d words %0d dones want 0 0", mon_d.size(), mon_g.size());
        end
        n_checks++;
        if (drop_count_out !== 16'd0 || src_mac_out !== 48'h0 || len_out !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %0d/%h/%h want 0/0/0", drop_count_out, src_mac_out, len_out);
        end
        send_frame(-1, 0);
        idle(4);
        n_checks++;
        if (mon_g.size() != 1 || (mon_g.size() == 1 && mon_g[0] !== 1'b1) || drop_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_next: got %0d dones drop %0d want 1 good, drop 0", mon_g.size(), drop_count_out);
        end
    endtask

    task automatic test_align();
        clear_mon();
        build_frame(BCAST, 21);
        send_frame(-1, 1);
        drive(1'b0, 2'b00);
        @(negedge clk_in);
        n_checks++;
        if ({done_out, good_out, axiov, axiol} !== 4'b1011) begin
            n_fail++;
            $display("FAIL align_end: got done/good/v/l=%b want 1011", {done_out, good_out, axiov, axiol});
        end
        idle(3);
        n_checks++;
        if (mon_d.size() != 6 || (mon_d.size() == 6 && mon_l[5] !== 1'b1)) begin
            n_fail++;
            $display("FAIL align_words: got %0d words want 6 with last flagged", mon_d.size());
        end
    endtask

    task automatic test_short();
        clear_mon();
        build_frame(BCAST, 21);
        send_preamble(-1);
        for (int k = 0; k < 9; k++) send_byte(frame[k]);
        idle(4);
        n_checks++;
        if (mon_g.size() != 1 || (mon_g.size() == 1 && mon_g[0] !== 1'b0) || mon_d.size() != 0) begin
            n_fail++;
            $display("FAIL short_verdict: got %0d dones %0d words want 1 bad done, 0 words", mon_g.size(), mon_d.size());
        end
        n_checks++;
        if (drop_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL short_drop: got %0d want 0", drop_count_out);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        build_frame(BCAST, 21);
        send_frame(-1, 0);
        drive(1'b0, 2'b00);
        send_frame(-1, 0);
        idle(4);
        n_checks++;
        if (mon_g.size() != 2 || (mon_g.size() == 2 && (mon_g[0] !== 1'b1 || mon_g[1] !== 1'b1))) begin
            n_fail++;
            $display("FAIL b2b_verdicts: got %0d dones want 2 good", mon_g.size());
        end
        n_checks++;
        if (mon_d.size() != 12 || (mon_d.size() == 12 &&
            (mon_l[5] !== 1'b1 || mon_l[11] !== 1'b1 || mon_d[6] !== exp_word(0)))) begin
            n_fail++;
            $display("FAIL b2b_words: got %0d words want 12 with two last flags", mon_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_fcs_flip();
        test_dest_filter();
        test_preamble_err();
        test_reset_mid();
        test_align();
        test_short();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_frame_rx.md
# eth_frame_rx

Parametrised RMII Ethernet frame receiver for the 50 MHz networking domain. It consumes raw `crsdv`/`rxd` dibits from the PHY and works through preamble/SFD, destination filter, source and length capture, payload and FCS in a single state machine. Payload is repacked into `OUT_W`-bit words on a valid/last/keep stream. A per-frame good/bad verdict and a saturating drop counter are also produced. It replaces the fixed-function byte receiver, address firewall and checksum chain between the PHY pins and the aggregation logic in `top_level`.

## Interface
- Clocking: one clock (`clk_in`); reset `rst_in` is synchronous and active-high.
- `OUT_W`, 32, payload word width in bits; multiple of 8, range 8–64.
- `MAC_ADDR`, 48'h0000_0000_0000, own address; first wire byte is `[47:40]`.
- `MIN_PREAMBLE`, 16, minimum count of `01` dibits before the SFD's final `11` dibit.
- `CNT_W`, 16, drop-counter width.
- `clk_in`  in  1  50 MHz RMII reference clock.
- `rst_in`  in  1  synchronous active-high reset.
- `crsdv_in`  in  1  carrier sense / data valid.
- `rxd_in`  in  2  receive dibit; the first dibit of each byte is bits [1:0].
- `axiov`  out  1  payload word valid; one-cycle pulse.
- `axiod`  out  OUT_W  payload word; first received byte in the MS byte.
- `axiok`  out  OUT_W/8  byte keep, MSB-aligned; all ones except on the last word.
- `axiol`  out  1  last payload word of the frame.
- `done_out`  out  1  one-cycle end-of-frame pulse (accepted frames only).
- `good_out`  out  1  frame verdict; valid only while `done_out` is high.
- `src_mac_out`  out  48  source MAC; first wire byte in `[47:40]`; stable from SRC exit until the next frame's SRC exit.
- `len_out`  out  16  length/type field; big-endian, first byte is MSB.
- `drop_count_out`  out  CNT_W  saturating count of dropped frames.

## Operation
- States: ARM, IDLE, PREAMBLE, DEST, SRC, LEN, PAYLOAD, DROP.
- ARM (entered on reset): wait for `crsdv_in`=0, then go to IDLE. A frame in progress when reset releases is ignored and not counted.
- IDLE: on `crsdv_in`=1 with dibit `01`, go to PREAMBLE.
- PREAMBLE: count consecutive `01` dibits.
  - Dibit `11` with count ≥ `MIN_PREAMBLE` → DEST.
  - Any other dibit, or `11` too early → DROP (counted).
- DEST: 24 dibits. Accept if the assembled address equals `MAC_ADDR` or all ones → SRC. Otherwise → DROP (counted).
- SRC: 24 dibits, then LEN. LEN: 8 dibits, then PAYLOAD.
- PAYLOAD:
  - Each completed byte enters a 4-byte holdback FIFO. The byte pushed out of the FIFO is appended to the word register.
  - A full word is emitted (`axiov`, `axiok` all ones) when the next byte would enter an empty word slot.
  - When `crsdv_in` falls, the 4 held bytes are FCS and are discarded. The partial or full word still in the register is emitted with `axiol`=1 and its keep pattern.
- Verdict: `good_out`=1 only if all of the following hold:
  - the CRC check passes;
  - the dibit phase is 0 at `crsdv_in` fall (otherwise alignment error);
  - at least 1 payload byte plus 4 FCS bytes were received.
- If no payload byte was emitted, `done_out` pulses with `good_out`=0 and no `axiov`.
- DROP: wait for `crsdv_in`=0, then IDLE. `drop_count_out` increments once on DROP entry and saturates at all ones.
- `crsdv_in` falling in DEST/SRC/LEN: `done_out` pulses with `good_out`=0 and no payload output; not counted as a drop.
- Reset mid-frame: go to ARM and clear all outputs, FIFO and counters.

## Timing
- Reset values: `axiov`, `axiol`, `done_out`, `good_out` = 0; `axiod`, `axiok`, `src_mac_out`, `len_out`, `drop_count_out` = 0.
- One dibit is sampled per `clk_in` edge while `crsdv_in`=1. A byte completes on the edge its 4th dibit is sampled.
- A full word's `axiov` is asserted on the cycle after the byte that displaces it from the FIFO is sampled.
- The final word (`axiov`=`axiol`=1), `done_out` and `good_out` all assert together, on the cycle after `crsdv_in` is first sampled low.
- Back-to-back frames: IDLE is re-entered the same cycle `done_out` pulses. A new frame may start on the next cycle.

## Configuration
- `ETH_FRAME_RX_CRC_EN` defined:
  - reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF), updated per dibit LSB-first over destination through FCS, no final XOR;
  - pass condition is a register value of 32'hDEBB20E3 after the last FCS dibit.
- Undefined: no CRC logic is built. The verdict uses only the alignment and minimum-length checks. FCS bytes are still stripped.

## Test plan
- Broadcast frame with the following contents → 6 `axiov` words, the last with `axiol`=1 and `axiok`=4'b1000; `done_out`,`good_out`=1; `src_mac_out`=48'h96C2_083075FD; `len_out`=16'h0015:
  - 31 `01` dibits, then `11`;
  - source bytes 96 C2 08 30 75 FD;
  - length 00 15;
  - 21 payload bytes and a valid FCS;
  - `OUT_W`=32.
- Same frame with one FCS bit flipped → identical payload words; `good_out`=0 with CRC enabled, 1 with the macro undefined.
- Destination 02:00:00:00:00:01 with `MAC_ADDR`=0 → no `axiov`, no `done_out`; `drop_count_out` 0→1.
- Preamble with a `00` dibit at position 10 → DROP, `drop_count_out`+1. A following valid frame → `good_out`=1.
- `rst_in` pulsed for 1 cycle mid-payload while `crsdv_in` stays high for 40 more dibits → no outputs. The next full frame → `good_out`=1 and `drop_count_out`=0.
- `crsdv_in` falls one dibit after a byte boundary → `done_out`=1, `good_out`=0, with the last word flagged `axiol`.
